pico_io_host: RTL

Host-side driver for the picoMIPS board I/O: it plays the role of the person at the switches. It accepts operand bytes on a valid/ready stream, presents each byte on `sw[7:0]`, and strobes the branch flag `sw[8]` so the processor's polling loop consumes it. After the last operand it waits a settle time, then captures `led` as the result. It also drives the processor reset `sw[9]`. It sits between a testbench or UART front end and the `picoMIPS` top.

---
 rtl/pico_io_pkg.sv | 34 +++
 rtl/pico_io_timer.sv | 34 +++
 rtl/pico_io_host.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pico_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pico_io_pkg
// Brief    : Shared state encoding, switch-bank bit positions and helpers
//            for the picoMIPS board I/O host driver.
// Revision : 1.0 - initial release
// ============================================================================
package pico_io_pkg;

    typedef enum logic [2:0] {
        ST_RST_CPU = 3'd0,
        ST_WAIT_OP = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_GAP     = 3'd4,
        ST_SETTLE  = 3'd5,
        ST_CAPTURE = 3'd6
    } host_state_t;

    localparam int SW_RST_BIT   = 9;
    localparam int SW_BFLAG_BIT = 8;
    localparam int SW_DATA_W    = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pico_io_timer.sv
`default_nettype none
// ============================================================================
// Module   : pico_io_timer
// Brief    : Loadable down-counter that saturates at zero; one instance times
//            every fixed-length state of the host sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module pico_io_timer #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= INIT;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pico_io_host.sv
`default_nettype none
// ============================================================================
// Module   : pico_io_host
// Brief    : Plays the operator at the picoMIPS switches: feeds operand bytes
//            with a Bflag handshake, then captures the LED result.
// Revision : 1.0 - initial release
// ============================================================================
module pico_io_host
    import pico_io_pkg::*;
#(
    parameter int N_OPS      = 2,
    parameter int RST_CYCLES = 2,
    parameter int HOLD       = 4,
    parameter int GAP        = 4,
    parameter int SETTLE     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SW_DATA_W-1:0] op_data,
    input  logic                 op_valid,
    output logic                 op_ready,
    output logic [SW_DATA_W-1:0] res_data,
    output logic                 res_valid,
    output logic                 busy,
    output logic [9:0]           sw,
    input  logic [SW_DATA_W-1:0] led
);

    localparam int c_max_dur = max4(RST_CYCLES, HOLD, GAP, SETTLE);
    localparam int c_tmr_w   = (c_max_dur > 1) ? $clog2(c_max_dur) : 1;
    localparam int c_cnt_w   = $clog2(N_OPS + 1);

    localparam logic [c_tmr_w-1:0] c_ld_rst    = c_tmr_w'(RST_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_ld_hold   = c_tmr_w'(HOLD - 1);
    localparam logic [c_tmr_w-1:0] c_ld_gap    = c_tmr_w'(GAP - 1);
    localparam logic [c_tmr_w-1:0] c_ld_settle = c_tmr_w'(SETTLE - 1);
    localparam logic [c_cnt_w-1:0] c_n_ops     = c_cnt_w'(N_OPS);

    if (N_OPS < 1 || RST_CYCLES < 1 || HOLD < 1 || GAP < 1 || SETTLE < 1) begin : g_param_check
        $error("pico_io_host: N_OPS, RST_CYCLES, HOLD, GAP and SETTLE must all be >= 1");
    end

    host_state_t            r_state;
    host_state_t            w_state_nxt;
    logic [c_cnt_w-1:0]     r_op_cnt;
    logic [c_cnt_w-1:0]     w_cnt_inc;
    logic [SW_DATA_W-1:0]   r_data;
    logic [SW_DATA_W-1:0]   r_res;
    logic                   w_accept;
    logic                   w_tmr_load;
    logic [c_tmr_w-1:0]     w_tmr_value;
    logic                   w_tmr_zero;

    // The reset preload makes RST_CPU last exactly RST_CYCLES after release.
    pico_io_timer #(
        .WIDTH (c_tmr_w),
        .INIT  (c_ld_rst)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_tmr_load),
        .value (w_tmr_value),
        .zero  (w_tmr_zero)
    );

    assign w_accept  = (r_state == ST_WAIT_OP) && op_valid;
    assign w_cnt_inc = r_op_cnt + c_cnt_w'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RST_CPU;
            r_op_cnt <= '0;
            r_data   <= '0;
            r_res    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data <= op_data;
            end
            if (r_state == ST_RST_CPU || r_state == ST_CAPTURE) begin
                r_op_cnt <= '0;
            end else if (r_state == ST_GAP && w_tmr_zero) begin
                r_op_cnt <= w_cnt_inc;
            end
            // Sampled on the edge entering CAPTURE so res_data is already
            // valid during the res_valid cycle.
            if (r_state == ST_SETTLE && w_tmr_zero) begin
                r_res <= led;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        case (r_state)
            ST_RST_CPU: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (op_valid) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_STROBE;
                w_tmr_load  = 1'b1;
                w_tmr_value = c_ld_hold;
            end
            ST_STROBE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_GAP;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_ld_gap;
                end
            end
            ST_GAP: begin
                if (w_tmr_zero) begin
                    if (w_cnt_inc == c_n_ops) begin
                        w_state_nxt = ST_SETTLE;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = c_ld_settle;
                    end else begin
                        w_state_nxt = ST_WAIT_OP;
                    end
                end
            end
            ST_SETTLE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_WAIT_OP;
            end
            default: begin
                w_state_nxt = ST_RST_CPU;
            end
        endcase
    end

    always_comb begin
        sw                   = '0;
        sw[SW_DATA_W-1:0]    = r_data;
        sw[SW_BFLAG_BIT]     = (r_state == ST_STROBE);
        sw[SW_RST_BIT]       = (r_state == ST_RST_CPU);
    end

    assign op_ready  = (r_state == ST_WAIT_OP);
    assign res_valid = (r_state == ST_CAPTURE);
    assign res_data  = r_res;
    assign busy      = !((r_state == ST_WAIT_OP) && (r_op_cnt == '0));

endmodule
`default_nettype wire
